// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU with HI/LO
// result registers, single-cycle MTHI/MTLO, and a combinational MFHI/MFLO read mux.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_out
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_long;
  logic        w_done;
  logic [63:0] w_ma;
  logic [63:0] w_mb;
  logic [63:0] w_prod;
  logic        w_sdiv;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_ua;
  logic [31:0] w_ub;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_long = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                  (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
  assign w_done = (r_state == S_RUN) && (r_cnt == 5'd1);
  assign busy   = (r_state == S_RUN);
  assign hi     = r_hi;
  assign lo     = r_lo;

  // One 64x64 multiplier serves both flavours: sign- or zero-extend the
  // latched operands and keep the low 64 bits of the product.
  assign w_ma   = (r_op == OP_MULT) ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
  assign w_mb   = (r_op == OP_MULT) ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
  assign w_prod = w_ma * w_mb;

  // Signed divide via magnitudes; this makes 0x80000000 / -1 fall out as
  // quotient 0x80000000, remainder 0 without a special case.
  assign w_sdiv  = (r_op == OP_DIV);
  assign w_neg_a = w_sdiv & r_a[31];
  assign w_neg_b = w_sdiv & r_b[31];
  assign w_ua    = w_neg_a ? (32'd0 - r_a) : r_a;
  assign w_ub    = w_neg_b ? (32'd0 - r_b) : r_b;
  assign w_uq    = w_ua / w_ub;
  assign w_ur    = w_ua % w_ub;
  assign w_q     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
  assign w_r     = w_neg_a ? (32'd0 - w_ur) : w_ur;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: issue of a long op starts RUN, counter reaching 1 ends it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start && w_long) w_next = S_RUN;
      S_RUN:  if (r_cnt == 5'd1)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, cycle counter, and HI/LO updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        case (mdu_op)
          OP_MULT, OP_MULTU: begin
            r_op  <= mdu_op;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= 5'(MULT_CYCLES);
          end
          OP_DIV, OP_DIVU: begin
            r_op  <= mdu_op;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= 5'(DIV_CYCLES);
          end
          OP_MTHI: r_hi <= a;
          OP_MTLO: r_lo <= a;
          default: ;
        endcase
      end
    end else if (w_done) begin
      r_cnt <= '0;
      if ((r_op == OP_MULT) || (r_op == OP_MULTU)) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end else if (r_b != '0) begin
        r_hi <= w_r;
        r_lo <= w_q;
      end
    end else begin
      r_cnt <= r_cnt - 5'd1;
    end
  end

  // Read mux for MFHI/MFLO, driven straight from the current op code.
  always_comb begin
    rd_out = '0;
    case (mdu_op)
      OP_MFHI: rd_out = r_hi;
      OP_MFLO: rd_out = r_lo;
      default: rd_out = '0;
    endcase
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of MULT/MULTU, in cycles; legal range 1..31.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of DIV/DIVU, in cycles; legal range 1..31.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  E-stage issue strobe for the operation on mdu_op; sampled at the rising edge.
REQ-007 mdu_op  input  4  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; codes 9-15 SHALL behave as NOP.
REQ-008 a  input  32  rs operand (dividend, multiplicand, or MTHI/MTLO data).
REQ-009 b  input  32  rt operand (divisor or multiplier).
REQ-010 busy  output  1  high while a multiply or divide is in flight.
REQ-011 hi  output  32  current HI register.
REQ-012 lo  output  32  current LO register.
REQ-013 rd_out  output  32  equals hi when mdu_op==MFHI, lo when mdu_op==MFLO, else 0; combinational, with no start required.

Function
REQ-014 The block SHALL implement two states: IDLE and RUN.
REQ-015 IDLE->RUN on an edge with start=1, busy=0 and mdu_op in {1..4}: the block SHALL latch a, b, mdu_op and load the cycle counter with MULT_CYCLES or DIV_CYCLES.
REQ-016 busy SHALL be 1 exactly in RUN, i.e. for N consecutive cycles starting the cycle after the issue edge.
REQ-017 RUN->IDLE at the edge ending the Nth busy cycle: hi/lo SHALL take the result on that same edge, and busy SHALL be 0 in the following cycle.
REQ-018 Result latency: the issue edge is t0 and hi/lo are valid from the cycle after edge t0+N.
REQ-019 MULT: {hi,lo} SHALL equal the signed 64-bit product a*b.
REQ-020 MULTU: {hi,lo} SHALL equal the unsigned 64-bit product a*b.
REQ-021 DIV: lo SHALL equal the signed quotient truncated toward zero; hi SHALL equal the remainder, carrying the sign of the dividend.
REQ-022 DIV with a=0x80000000 and b=0xFFFFFFFF: lo SHALL be 0x80000000 and hi SHALL be 0.
REQ-023 DIVU: lo SHALL equal a/b and hi SHALL equal a%b, both unsigned.
REQ-024 Divide by zero (b==0, DIV or DIVU): the block SHALL run the full DIV_CYCLES with busy high, then leave hi/lo unchanged.
REQ-025 Results SHALL be computed from the operands latched at issue; changes on a or b during RUN SHALL have no effect.
REQ-026 MTHI on an edge with start=1 and busy=0: hi<=a, lo unchanged, no busy cycles.
REQ-027 MTLO on an edge with start=1 and busy=0: lo<=a, hi unchanged, no busy cycles.
REQ-028 Any start while busy=1 SHALL be ignored (no state change); the pipeline stalls on busy|start for mdu ops.
REQ-029 A start that coincides with the completion edge SHALL be ignored, because busy is still 1 on that edge.
REQ-030 MFHI/MFLO with start=1 SHALL NOT change any state.
REQ-031 During RUN, hi and lo SHALL hold their pre-issue values until the completion edge.

Reset
REQ-032 While rst_n=0, regardless of clk: state=IDLE, busy=0, hi=0, lo=0, counter=0, latched operands=0.
REQ-033 Reset asserted during RUN SHALL abort the operation with no hi/lo update, and no stale completion SHALL occur after release.
REQ-034 The first issue SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-035 Signed multiply: MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-036 Signed and unsigned divide: DIV a=-7, b=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1); DIVU a=7, b=2 -> lo=3 and hi=1.
REQ-037 Divide-by-zero and overflow corners: after MTHI a=0x11 and MTLO a=0x22, DIV b=0 -> 10 busy cycles, then hi=0x11 and lo=0x22; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 and hi=0.
REQ-038 Issue while busy: MULTU 0xFFFFFFFF*0xFFFFFFFF, then MTLO a=5 on busy cycle 2 and again on the completion edge -> both ignored, hi=0xFFFFFFFE, lo=0x00000001.
REQ-039 Reset mid-operation: DIV issued, rst_n pulsed low on busy cycle 4 -> busy=0 and hi=lo=0 immediately, and they remain 0 with no update afterwards.
REQ-040 Read mux and operand capture: mdu_op=MFHI/MFLO gives rd_out=hi/lo in the same cycle; changing a and b during RUN leaves the result unchanged.
